// File: rtl/pll_lock_if.sv
// ---------------------------------------------------------------------------
// pll_lock_if
//   Bundle between the PLL-side world and the lock supervisor.
//   Everything lives in the PLL output clock domain, except 'locked'. That
//   signal is the raw PLL lock and is asynchronous to the clock.
//
//   Signals
//     locked           raw PLL lock indication (async)
//     clear_stats      1-cycle pulse clearing the sticky debug status
//     rst_out_n        fabric reset, active-low
//     ready            high only while the supervisor is in RUN
//     lock_lost        sticky: lock dropped while running
//     lock_timeout     sticky: lock took too long to appear
//     lock_loss_count  saturating count of lock losses while running
//
//   Modports
//     master  environment / status consumer (drives locked, clear_stats)
//     slave   the supervisor itself
// ---------------------------------------------------------------------------
interface pll_lock_if #(
    parameter int CNT_W = 8
);
    logic             locked;
    logic             clear_stats;
    logic             rst_out_n;
    logic             ready;
    logic             lock_lost;
    logic             lock_timeout;
    logic [CNT_W-1:0] lock_loss_count;

    modport master (
        output locked,
        output clear_stats,
        input  rst_out_n,
        input  ready,
        input  lock_lost,
        input  lock_timeout,
        input  lock_loss_count
    );

    modport slave (
        input  locked,
        input  clear_stats,
        output rst_out_n,
        output ready,
        output lock_lost,
        output lock_timeout,
        output lock_loss_count
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor
//   Runs in the PLL output clock domain. It turns the raw PLL lock flag into
//   a glitch-filtered fabric reset. The reset asserts asynchronously and
//   releases synchronously. The block also keeps lock-loss and timeout status
//   for debug.
//
//   Flow: WAIT_LOCK -> STABILIZE -> HOLD -> RUN
//     - The raw lock signal passes through a 2-flop synchroniser.
//     - A lock that drops before RUN sends the FSM back to WAIT_LOCK.
//       This drop is not counted.
//     - A lock that drops in RUN sends the FSM back to WAIT_LOCK on the same
//       edge. That edge also pulls rst_out_n low and updates the loss stats.
//
//   Ports
//     clk_in   PLL output clock (only clock)
//     resetn   async active-low reset
//     pll      pll_lock_if.slave: locked/clear_stats in, reset and status out
//
//   Every output is a flop. ready is the same flop as rst_out_n.
// ---------------------------------------------------------------------------
module pll_lock_supervisor #(
    parameter int LOCK_STABLE_CYCLES = 16,
    parameter int RESET_HOLD_CYCLES  = 32,
    parameter int LOCK_TIMEOUT       = 65535,
    parameter int CNT_W              = 8
) (
    input  logic       clk_in,
    input  logic       resetn,
    pll_lock_if.slave  pll
);

    // Width of the shared cycle counter.
    // The counter must reach LOCK_TIMEOUT + 1 in WAIT_LOCK, so the
    // timeout compare matches on exactly one cycle. If it could only
    // reach LOCK_TIMEOUT, the compare would match every cycle. A
    // clear_stats during a long wait would then never take effect.
    localparam int MAX_SH = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                            LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
    localparam int MAX_P  = (MAX_SH > LOCK_TIMEOUT) ? MAX_SH : LOCK_TIMEOUT;
    localparam int CW     = $clog2(MAX_P + 2);

    localparam logic [CW-1:0]    STABLE_C  = CW'(LOCK_STABLE_CYCLES);
    localparam logic [CW-1:0]    HOLD_C    = CW'(RESET_HOLD_CYCLES);
    localparam logic [CW-1:0]    TIMEOUT_C = CW'(LOCK_TIMEOUT);
    localparam logic [CW-1:0]    CYC_ONE   = CW'(1);
    localparam logic [CW-1:0]    CYC_MAX   = {CW{1'b1}};
    localparam logic [CNT_W-1:0] LOSS_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LOSS_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t           state_q,        state_d;
    logic [CW-1:0]    cnt_q,          cnt_d;
    logic [1:0]       locked_sync_q,  locked_sync_d;
    logic             rst_out_n_q,    rst_out_n_d;
    logic             lock_lost_q,    lock_lost_d;
    logic             lock_timeout_q, lock_timeout_d;
    logic [CNT_W-1:0] loss_cnt_q,     loss_cnt_d;
    logic [CNT_W-1:0] loss_base;
    logic             locked_s;

    assign locked_s = locked_sync_q[1];

    // Synchroniser: [0] is the metastability-catching stage, [1] is the
    // stage the FSM uses.
    always_comb begin
        locked_sync_d = {locked_sync_q[0], pll.locked};
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        lock_lost_d    = lock_lost_q;
        lock_timeout_d = lock_timeout_q;
        loss_cnt_d     = loss_cnt_q;

        // clear_stats goes in first, so an event on the same edge
        // overrides it.
        loss_base = pll.clear_stats ? '0 : loss_cnt_q;
        if (pll.clear_stats) begin
            lock_lost_d    = 1'b0;
            lock_timeout_d = 1'b0;
            loss_cnt_d     = '0;
        end

        case (state_q)
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABILIZE;
                    cnt_d   = CYC_ONE;
                end else begin
                    if (cnt_q == TIMEOUT_C)
                        lock_timeout_d = 1'b1;
                    if (cnt_q != CYC_MAX)
                        cnt_d = cnt_q + CYC_ONE;
                end
            end
            STABILIZE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_C) begin
                    state_d = HOLD;
                    cnt_d   = CYC_ONE;
                end else begin
                    cnt_d = cnt_q + CYC_ONE;
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_C) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CYC_ONE;
                end
            end
            RUN: begin
                // Loss while running: go straight back to WAIT_LOCK.
                // rst_out_n drops on this same edge because it
                // follows state_d.
                if (!locked_s) begin
                    state_d     = WAIT_LOCK;
                    cnt_d       = '0;
                    lock_lost_d = 1'b1;
                    loss_cnt_d  = (loss_base == LOSS_MAX) ?
                                  LOSS_MAX : loss_base + LOSS_ONE;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase

        // rst_out_n is registered from the next state. It rises on the
        // edge that enters RUN and falls on the edge that leaves it.
        rst_out_n_d = (state_d == RUN);
    end

    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            state_q        <= WAIT_LOCK;
            cnt_q          <= '0;
            locked_sync_q  <= '0;
            rst_out_n_q    <= 1'b0;
            lock_lost_q    <= 1'b0;
            lock_timeout_q <= 1'b0;
            loss_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            locked_sync_q  <= locked_sync_d;
            rst_out_n_q    <= rst_out_n_d;
            lock_lost_q    <= lock_lost_d;
            lock_timeout_q <= lock_timeout_d;
            loss_cnt_q     <= loss_cnt_d;
        end
    end

    assign pll.rst_out_n       = rst_out_n_q;
    assign pll.ready           = rst_out_n_q;
    assign pll.lock_lost       = lock_lost_q;
    assign pll.lock_timeout    = lock_timeout_q;
    assign pll.lock_loss_count = loss_cnt_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_supervisor
//   Directed bench. Parameters: LOCK_STABLE_CYCLES=4, RESET_HOLD_CYCLES=8,
//   LOCK_TIMEOUT=20, CNT_W=2.
//
//   Timing convention: "origin" is the first rising edge that samples
//   locked=1. rst_out_n must still be low 13 edges after the origin and
//   high 14 edges after it.
//
//   Inputs change 1 ns after a rising edge. Outputs are sampled at that
//   same point.
// ---------------------------------------------------------------------------
module tb_pll_lock_supervisor;
    localparam int LS = 4;
    localparam int RH = 8;
    localparam int LT = 20;
    localparam int CW = 2;

    logic clk    = 1'b0;
    logic resetn = 1'b1;

    pll_lock_if #(.CNT_W(CW)) pif ();

    pll_lock_supervisor #(
        .LOCK_STABLE_CYCLES (LS),
        .RESET_HOLD_CYCLES  (RH),
        .LOCK_TIMEOUT       (LT),
        .CNT_W              (CW)
    ) dut (
        .clk_in (clk),
        .resetn (resetn),
        .pll    (pif.slave)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_stats(input string tag, input logic lost, input logic tmo,
                             input logic [CW-1:0] cnt);
        chk({tag, ".lock_lost"},    32'(pif.lock_lost),       32'(lost));
        chk({tag, ".lock_timeout"}, 32'(pif.lock_timeout),    32'(tmo));
        chk({tag, ".loss_count"},   32'(pif.lock_loss_count), 32'(cnt));
    endtask

    // Call this right after the origin edge.
    task automatic expect_release(input string tag);
        tick(13);
        chk({tag, ".rst_e13"},   32'(pif.rst_out_n), 32'd0);
        tick(1);
        chk({tag, ".rst_e14"},   32'(pif.rst_out_n), 32'd1);
        chk({tag, ".ready_e14"}, 32'(pif.ready),     32'd1);
    endtask

    // Leaves resetn released mid-cycle, with locked already at lk.
    task automatic do_reset(input logic lk);
        pif.locked = lk;
        resetn     = 1'b0;
        tick(2);
        resetn     = 1'b1;
    endtask

    // Start in RUN. Hold locked low for 5 edges, then relock and expect
    // the reset to be released again.
    task automatic lose_lock(input string tag, input logic [CW-1:0] exp_cnt);
        pif.locked = 1'b0;
        tick(2);
        chk({tag, ".rst_e2"}, 32'(pif.rst_out_n), 32'd1);
        tick(1);
        chk({tag, ".rst_e3"},   32'(pif.rst_out_n), 32'd0);
        chk({tag, ".ready_e3"}, 32'(pif.ready),     32'd0);
        chk_stats(tag, 1'b1, 1'b0, exp_cnt);
        tick(2);
        pif.locked = 1'b1;
        tick(1);
        expect_release({tag, ".relock"});
    endtask

    initial begin
        pif.locked      = 1'b0;
        pif.clear_stats = 1'b0;

        // Reset state.
        #2 resetn = 1'b0;
        #1;
        chk("rst.rst_out_n", 32'(pif.rst_out_n), 32'd0);
        chk("rst.ready",     32'(pif.ready),     32'd0);
        chk_stats("rst", 1'b0, 1'b0, 2'd0);

        // Test 1: locked is steady high from the reset release.
        do_reset(1'b1);
        tick(1);
        expect_release("t1");
        chk_stats("t1", 1'b0, 1'b0, 2'd0);

        // Test 2: lose lock in RUN, then relock.
        lose_lock("t2", 2'd1);

        // Test 3a: 1-cycle glitch during STABILIZE. The FSM moves to
        // STABILIZE on edge 2 after the origin; the glitch is sampled on
        // edge 4, so edge 5 becomes the new origin.
        do_reset(1'b1);
        tick(1);
        tick(3);
        pif.locked = 1'b0;
        tick(1);
        pif.locked = 1'b1;
        tick(1);
        expect_release("t3a");
        chk_stats("t3a", 1'b0, 1'b0, 2'd0);

        // Test 3b: 1-cycle glitch during HOLD. HOLD covers edges 6..14
        // after the origin; the glitch is sampled on edge 9, so edge 10
        // becomes the new origin.
        do_reset(1'b1);
        tick(1);
        tick(8);
        pif.locked = 1'b0;
        tick(1);
        pif.locked = 1'b1;
        tick(1);
        expect_release("t3b");
        chk_stats("t3b", 1'b0, 1'b0, 2'd0);

        // Test 4: timeout. The counter reads 20 on edge 21 after release.
        do_reset(1'b0);
        tick(20);
        chk("t4.tmo_e20", 32'(pif.lock_timeout), 32'd0);
        tick(1);
        chk("t4.tmo_e21", 32'(pif.lock_timeout), 32'd1);
        tick(4);
        pif.locked = 1'b1;
        tick(1);
        expect_release("t4");
        chk("t4.tmo_sticky", 32'(pif.lock_timeout), 32'd1);
        pif.clear_stats = 1'b1;
        tick(1);
        pif.clear_stats = 1'b0;
        chk("t4.tmo_clr", 32'(pif.lock_timeout), 32'd0);
        chk("t4.run_clr", 32'(pif.rst_out_n),    32'd1);

        // Test 4b: clear_stats on the same edge as the timeout hit.
        do_reset(1'b0);
        tick(20);
        pif.clear_stats = 1'b1;
        tick(1);
        pif.clear_stats = 1'b0;
        chk("t4b.tmo_vs_clr", 32'(pif.lock_timeout), 32'd1);

        // Test 5: the loss count saturates at 3. Then clear_stats lands on
        // the same edge as a sixth loss.
        do_reset(1'b1);
        tick(1);
        expect_release("t5");
        for (int i = 1; i <= 5; i++) begin
            lose_lock($sformatf("t5.loss%0d", i), (i > 3) ? 2'd3 : CW'(i));
        end
        pif.locked = 1'b0;
        tick(2);
        pif.clear_stats = 1'b1;
        tick(1);
        pif.clear_stats = 1'b0;
        chk("t5.clr_rst", 32'(pif.rst_out_n), 32'd0);
        chk_stats("t5.clr", 1'b1, 1'b0, 2'd1);
        tick(2);
        pif.locked = 1'b1;
        tick(1);
        expect_release("t5.final");

        // Test 6: pulse resetn in RUN. The outputs must drop with no
        // clock edge.
        #2 resetn = 1'b0;
        #1;
        chk("t6.rst_async",   32'(pif.rst_out_n), 32'd0);
        chk("t6.ready_async", 32'(pif.ready),     32'd0);
        chk_stats("t6", 1'b0, 1'b0, 2'd0);
        tick(1);
        resetn = 1'b1;
        tick(1);
        expect_release("t6");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
